// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Also imported by the hazard-detect unit reused in forwarding verification.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN,
        DROP
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the register reads in ID.
// Purely combinational so the forwarding-unit bench can reuse it.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_dm_oe,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1_addr == ex_rd_addr);
    assign rs2_hit  = id_use_rs2 && (id_rs2_addr == ex_rd_addr);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    assign load_use = ex_dm_oe && (ex_rd_addr != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencing for the 5-stage core, wrong-path fetch squashing,
// and saturating stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_DM_OE,
    input  logic             i_ex_redirect,
    input  logic             i_im_busy,
    input  logic             i_dm_busy,
    input  logic             i_im_outstanding,
    input  logic             i_im_rvalid,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_stall,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_stall,
    output logic             o_mem_wb_stall,
    output logic             o_drop_fetch,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_state_t state;
    logic        freeze;
    logic        load_use;
    logic        redirect_taken;

    hazard_detect u_hazard_detect (
        .id_rs1_addr (i_id_rs1_addr),
        .id_rs2_addr (i_id_rs2_addr),
        .id_use_rs1  (i_id_use_rs1),
        .id_use_rs2  (i_id_use_rs2),
        .ex_rd_addr  (i_ex_rd_addr),
        .ex_dm_oe    (i_ex_DM_OE),
        .load_use    (load_use)
    );

    assign freeze         = i_im_busy | i_dm_busy;
    assign redirect_taken = ~freeze & i_ex_redirect;

    // Priority: reset, memory freeze, redirect, load-use bubble
    always_comb begin
        o_pc_stall     = 1'b0;
        o_if_id_stall  = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_stall  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_stall = 1'b0;
        o_mem_wb_stall = 1'b0;
        o_drop_fetch   = 1'b0;
        if (rst) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
        end else begin
            o_drop_fetch = (state == DROP) && i_im_rvalid;
            if (freeze) begin
                o_pc_stall     = 1'b1;
                o_if_id_stall  = 1'b1;
                o_id_ex_stall  = 1'b1;
                o_ex_mem_stall = 1'b1;
                o_mem_wb_stall = 1'b1;
            end else if (i_ex_redirect) begin
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
            end else if (load_use) begin
                o_pc_stall    = 1'b1;
                o_if_id_stall = 1'b1;
                o_id_ex_flush = 1'b1;
            end
        end
    end

    // A response arriving with a fresh redirect belongs to the flushed IF/ID slot;
    // only a still-outstanding request makes the next response wrong-path
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_taken && i_im_outstanding) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (i_im_rvalid && !(redirect_taken && i_im_outstanding)) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_stall_cycles <= '0;
        end else if (o_pc_stall && (o_stall_cycles != CNT_MAX)) begin
            o_stall_cycles <= o_stall_cycles + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_flush_count <= '0;
        end else if (redirect_taken && (o_flush_count != CNT_MAX)) begin
            o_flush_count <= o_flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// all compared every cycle against a behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1, rs2, rd;
    logic             use1, use2, ld, redir, imb, dmb, outst, rvalid;
    logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic             ex_mem_stall, mem_wb_stall, drop_fetch;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int tests = 0;
    int fails = 0;

    // Model: whether the next IM response is wrong-path, and the two event counts
    bit model_wrong_path = 0;
    int model_stalls = 0;
    int model_flushes = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_id_rs1_addr    (rs1),
        .i_id_rs2_addr    (rs2),
        .i_id_use_rs1     (use1),
        .i_id_use_rs2     (use2),
        .i_ex_rd_addr     (rd),
        .i_ex_DM_OE       (ld),
        .i_ex_redirect    (redir),
        .i_im_busy        (imb),
        .i_dm_busy        (dmb),
        .i_im_outstanding (outst),
        .i_im_rvalid      (rvalid),
        .o_pc_stall       (pc_stall),
        .o_if_id_stall    (if_id_stall),
        .o_if_id_flush    (if_id_flush),
        .o_id_ex_stall    (id_ex_stall),
        .o_id_ex_flush    (id_ex_flush),
        .o_ex_mem_stall   (ex_mem_stall),
        .o_mem_wb_stall   (mem_wb_stall),
        .o_drop_fetch     (drop_fetch),
        .o_stall_cycles   (stall_cycles),
        .o_flush_count    (flush_count)
    );

    task automatic setIdle();
        rst = 0; rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0; ld = 0;
        redir = 0; imb = 0; dmb = 0; outst = 0; rvalid = 0;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkCnt(input string tag, input logic [CNT_W-1:0] obs, input int exp);
        tests++;
        assert (obs === CNT_W'(exp)) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compares all outputs against the model, then advances the model one clock
    task automatic checkOutput(input string tag);
        bit frz, hazard, e_pc, e_ifs, e_iff, e_ids, e_idf, e_late, e_drop;
        frz    = imb || dmb;
        hazard = ld && (rd != 0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
        e_pc = 0; e_ifs = 0; e_iff = 0; e_ids = 0; e_idf = 0; e_late = 0; e_drop = 0;
        if (rst) begin
            e_iff = 1; e_idf = 1;
        end else begin
            e_drop = model_wrong_path && rvalid;
            if (frz) begin
                e_pc = 1; e_ifs = 1; e_ids = 1; e_late = 1;
            end else if (redir) begin
                e_iff = 1; e_idf = 1;
            end else if (hazard) begin
                e_pc = 1; e_ifs = 1; e_idf = 1;
            end
        end
        checkBit({tag, ".pc_stall"},     pc_stall,     e_pc);
        checkBit({tag, ".if_id_stall"},  if_id_stall,  e_ifs);
        checkBit({tag, ".if_id_flush"},  if_id_flush,  e_iff);
        checkBit({tag, ".id_ex_stall"},  id_ex_stall,  e_ids);
        checkBit({tag, ".id_ex_flush"},  id_ex_flush,  e_idf);
        checkBit({tag, ".ex_mem_stall"}, ex_mem_stall, e_late);
        checkBit({tag, ".mem_wb_stall"}, mem_wb_stall, e_late);
        checkBit({tag, ".drop_fetch"},   drop_fetch,   e_drop);
        checkCnt({tag, ".stall_cycles"}, stall_cycles, model_stalls);
        checkCnt({tag, ".flush_count"},  flush_count,  model_flushes);
        if (rst) begin
            model_wrong_path = 0;
            model_stalls     = 0;
            model_flushes    = 0;
        end else begin
            if (e_pc && model_stalls < CNT_SAT) model_stalls++;
            if (!frz && redir && model_flushes < CNT_SAT) model_flushes++;
            if (!frz && redir && outst) model_wrong_path = 1;
            else if (rvalid)            model_wrong_path = 0;
        end
    endtask

    // Inputs are already set; sample mid-cycle, then cross one rising edge
    task automatic applyStimulus(input string tag);
        #1;
        checkOutput(tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        setIdle();
        rst = 1;
        applyStimulus("reset0");
        applyStimulus("reset1");
        setIdle();
        applyStimulus("idle");

        // lw x5 in EX, add reading x5 in ID: one bubble
        ld = 1; rd = 5; rs1 = 5; use1 = 1;
        applyStimulus("load_use");
        setIdle();
        applyStimulus("after_load_use");
        checkCnt("lu_stall_count", stall_cycles, 1);

        // load to x0 never stalls
        ld = 1; rd = 0; rs1 = 0; use1 = 1;
        applyStimulus("rd_x0");

        // redirect with an outstanding fetch, response comes two cycles later
        setIdle();
        redir = 1; outst = 1;
        applyStimulus("redirect");
        redir = 0;
        applyStimulus("drop_wait");
        outst = 0; rvalid = 1;
        applyStimulus("drop_resp");
        rvalid = 0;
        applyStimulus("back_run");
        rvalid = 1;
        applyStimulus("run_resp_kept");
        checkCnt("redirect_flush_count", flush_count, 1);

        // data-memory freeze overlapping a load-use hazard
        setIdle();
        rst = 1;
        applyStimulus("reset_freeze");
        setIdle();
        ld = 1; rd = 7; rs2 = 7; use2 = 1; dmb = 1;
        for (int i = 0; i < 3; i++) applyStimulus("freeze_hazard");
        dmb = 0;
        applyStimulus("hazard_after_freeze");
        setIdle();
        applyStimulus("freeze_done");
        checkCnt("freeze_stall_count", stall_cycles, 4);

        // sustained load-use saturates the stall counter
        ld = 1; rd = 9; rs1 = 9; use1 = 1;
        for (int i = 0; i < 20; i++) applyStimulus("saturate");
        setIdle();
        applyStimulus("saturated");
        checkCnt("saturated_stall_count", stall_cycles, CNT_SAT);

        // reset while in DROP abandons the drop
        redir = 1; outst = 1;
        applyStimulus("enter_drop");
        redir = 0; rst = 1; rvalid = 1;
        applyStimulus("reset_in_drop");
        rst = 0; outst = 0;
        applyStimulus("resp_after_reset");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            rd     = 5'($urandom_range(0, 3));
            rs1    = 5'($urandom_range(0, 3));
            rs2    = 5'($urandom_range(0, 3));
            use1   = 1'($urandom);
            use2   = 1'($urandom);
            ld     = 1'($urandom);
            redir  = ($urandom_range(0, 4) == 0);
            imb    = ($urandom_range(0, 5) == 0);
            dmb    = ($urandom_range(0, 5) == 0);
            outst  = 1'($urandom);
            rvalid = ($urandom_range(0, 2) == 0);
            applyStimulus("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32I core on the AXI4 platform. It produces the stall and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three inputs:
- load-use hazards detected in the decode stage;
- taken control transfers resolved in execute;
- AXI instruction/data memory wait states.

It also tracks wrong-path instruction fetches that are still outstanding, so their responses are discarded, and keeps saturating performance counters of stall and flush activity.

## Interface
- CNT_W, 32: width of both performance counters.

- clk  input  1  core clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- i_id_rs1_addr  input  5  rs1 index of the instruction in ID.
- i_id_rs2_addr  input  5  rs2 index of the instruction in ID.
- i_id_use_rs1  input  1  ID instruction reads rs1.
- i_id_use_rs2  input  1  ID instruction reads rs2.
- i_ex_rd_addr  input  5  rd of the instruction in EX.
- i_ex_DM_OE  input  1  EX instruction is a load.
- i_ex_redirect  input  1  EX resolved a taken branch, jal or jalr.
- i_im_busy  input  1  instruction-memory AXI access is not yet complete.
- i_dm_busy  input  1  data-memory AXI access is not yet complete.
- i_im_outstanding  input  1  an IM read request has been issued and its response is not yet received.
- i_im_rvalid  input  1  IM read response accepted this cycle.
- o_pc_stall  output  1  hold PC.
- o_if_id_stall  output  1  hold IF/ID.
- o_if_id_flush  output  1  load a bubble into IF/ID.
- o_id_ex_stall  output  1  hold ID/EX.
- o_id_ex_flush  output  1  load a bubble into ID/EX.
- o_ex_mem_stall  output  1  hold EX/MEM.
- o_mem_wb_stall  output  1  hold MEM/WB.
- o_drop_fetch  output  1  squash the IM response accepted this cycle; it belongs to the wrong path.
- o_stall_cycles  output  CNT_W  cycles in which o_pc_stall=1; saturates.
- o_flush_count  output  CNT_W  number of redirects taken; saturates.

## Operation
- freeze = i_im_busy | i_dm_busy.
- load_use = i_ex_DM_OE & (i_ex_rd_addr != 0) & ((i_id_use_rs1 & rs1 == rd) | (i_id_use_rs2 & rs2 == rd)).
- The control outputs are combinational. Priority, highest first:
  1. freeze: every stall output =1, every flush output =0. A pending redirect or load-use condition is not acted on; EX is held, so the condition re-presents itself once freeze drops.
  2. i_ex_redirect: o_if_id_flush=1 and o_id_ex_flush=1; all stalls =0. If i_im_outstanding=1, the FSM moves to DROP. Load-use is ignored, because the ID instruction is being flushed.
  3. load_use: o_pc_stall=1 and o_if_id_stall=1, o_id_ex_flush=1. This inserts exactly one bubble.
  4. Otherwise all control outputs are 0.
- FSM (in the shared package) has two states:
  - RUN: o_drop_fetch=0. On an unfrozen redirect with i_im_outstanding=1, go to DROP.
  - DROP: o_drop_fetch = i_im_rvalid. On i_im_rvalid=1, go to RUN. If a new redirect arrives in the same cycle with i_im_outstanding still 1, stay in DROP.
  - Redirects while in DROP with no response yet: remain in DROP. Only one IM request is ever outstanding.
- Counters:
  - o_stall_cycles increments on each cycle with o_pc_stall=1.
  - o_flush_count increments on each unfrozen redirect.
  - Both hold at 2^CNT_W−1 and never wrap.
- rst=1 overrides everything:
  - FSM goes to RUN and both counters go to 0.
  - During rst the outputs are: o_if_id_flush=1, o_id_ex_flush=1, all stalls =0, o_drop_fetch=0.
  - Reset asserted while in DROP abandons the drop. The fetch unit's own reset discards the in-flight request.

## Timing
- Control outputs have zero-cycle latency: they are combinational from inputs and the state register, and are sampled by the stage registers at the next clk edge.
- Load-use costs exactly 1 stall cycle when unfrozen. It costs 1 + N cycles when a freeze of N cycles overlaps it.
- Redirect costs 2 bubbles, plus any cycles spent in DROP.
- The state register and counters update on the rising edge of clk. Counter values are visible in the cycle after the event.
- i_im_rvalid and i_ex_redirect in the same cycle while in RUN: that response is not dropped; it is the IF/ID content being flushed. The FSM enters DROP only if i_im_outstanding is still 1.

## Structure
- pipe_ctrl_pkg holds:
  - the typedef enum logic {RUN, DROP} for the FSM state;
  - localparam REG_ZERO = 5'd0.
- One sub-module, hazard_detect: purely combinational load_use compare. It is reused by the forwarding-unit verification.
- The counters are inline, as one always_ff block per counter with saturation.

## Test plan
- Load-use: lw x5 in EX (i_ex_DM_OE=1, rd=5), ID add with rs1=5 and use_rs1=1 → o_pc_stall, o_if_id_stall and o_id_ex_flush high for 1 cycle. o_stall_cycles goes 0→1.
- rd=x0: i_ex_DM_OE=1, rd=0, rs1=0 → no stall, all outputs 0.
- Redirect with outstanding fetch: i_ex_redirect=1, i_im_outstanding=1 → both flushes high and the FSM is in DROP. On the next i_im_rvalid, o_drop_fetch=1 for that cycle, then the FSM returns to RUN. o_flush_count=1.
- Freeze over hazard: i_dm_busy=1 for 3 cycles with load_use true → all stalls high and no flush for 3 cycles. Then 1 load-use bubble follows. o_stall_cycles=4.
- Saturation: with CNT_W=4, hold load_use for 20 cycles → o_stall_cycles sticks at 15.
- Reset in DROP: enter DROP, then assert rst for 1 cycle → o_drop_fetch=0, counters 0, both flushes high during rst. The FSM is in RUN after release.
